alarm_responder: RTL and testbench

ALARM_RESPONDER -- requirements
Module: alarm_responder

---
 rtl/clock_pkg.sv | 19 +
 rtl/edge_rise.sv | 25 ++
 rtl/alarm_responder.sv | 139 +++++++++++++
 tb/tb_alarm_responder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the alarm responder: state encoding, default timing
// parameters and counter widths.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int RING_TIMEOUT_S_DEF = 60;
  localparam int SNOOZE_S_DEF       = 300;
  localparam int MAX_SNOOZE_DEF     = 3;

  localparam int SEC_W = 9;
  localparam int SNZ_W = 2;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector on a clk-synchronous level. The first clock after reset
// only loads the history, so a level already high at release is not an edge.
module edge_rise (
  input  logic clk,
  input  logic cr,
  input  logic d,
  output logic pulse
);

  logic d_q;
  logic armed_q;

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      d_q     <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      d_q     <= d;
      armed_q <= 1'b1;
    end
  end

  assign pulse = d & ~d_q & armed_q;

endmodule

// File: rtl/alarm_responder.sv
// Alarm responder: rings on a new alarm match, handles stop/snooze buttons,
// ring timeout and snooze re-ring, and drives a 1 Hz buzzer square wave.
module alarm_responder
  import clock_pkg::*;
#(
  parameter int RING_TIMEOUT_S = RING_TIMEOUT_S_DEF,
  parameter int SNOOZE_S       = SNOOZE_S_DEF,
  parameter int MAX_SNOOZE     = MAX_SNOOZE_DEF
) (
  input  logic             clk,
  input  logic             cr,
  input  logic             en,
  input  logic             match,
  input  logic             tick_1hz,
  input  logic             tick_2hz,
  input  logic             stop_btn,
  input  logic             snooze_btn,
  output logic             buzzer,
  output logic             ringing,
  output logic             snoozing,
  output logic [SNZ_W-1:0] snooze_cnt,
  output logic [SEC_W-1:0] sec_cnt
);

  localparam logic [SEC_W-1:0] RING_LAST = SEC_W'(RING_TIMEOUT_S - 1);
  localparam logic [SEC_W-1:0] SNZ_LAST  = SEC_W'(SNOOZE_S - 1);
  localparam logic [SNZ_W-1:0] SNZ_MAX   = SNZ_W'(MAX_SNOOZE);

  logic match_rise;
  logic stop_rise;
  logic snz_rise;

  state_e           state_q, state_d;
  logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
  logic [SEC_W-1:0] sec_cnt_q;
  logic             buzzer_q;

  edge_rise u_match_edge (
    .clk   (clk),
    .cr    (cr),
    .d     (match),
    .pulse (match_rise)
  );

  edge_rise u_stop_edge (
    .clk   (clk),
    .cr    (cr),
    .d     (stop_btn),
    .pulse (stop_rise)
  );

  edge_rise u_snooze_edge (
    .clk   (clk),
    .cr    (cr),
    .d     (snooze_btn),
    .pulse (snz_rise)
  );

  // Button priority in RING is stop, then snooze, then timeout.
  always_comb begin
    state_d   = state_q;
    snz_cnt_d = snz_cnt_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (match_rise) state_d = ST_RING;
        end
        ST_RING: begin
          if (stop_rise) begin
            state_d = ST_DONE;
          end else if (snz_rise) begin
            if (snz_cnt_q < SNZ_MAX) begin
              state_d   = ST_SNOOZE;
              snz_cnt_d = snz_cnt_q + SNZ_W'(1);
            end else begin
              state_d = ST_DONE;
            end
          end else if (tick_1hz && (sec_cnt_q == RING_LAST)) begin
            state_d = ST_DONE;
          end
        end
        ST_SNOOZE: begin
          if (stop_rise) begin
            state_d = ST_DONE;
          end else if (tick_1hz && (sec_cnt_q == SNZ_LAST)) begin
            state_d = ST_RING;
          end
        end
        ST_DONE: begin
          if (!match) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (state_d == ST_IDLE) snz_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      state_q   <= ST_IDLE;
      snz_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      snz_cnt_q <= snz_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      sec_cnt_q <= '0;
    end else if (state_d != state_q) begin
      sec_cnt_q <= '0;
    end else if (tick_1hz && ((state_q == ST_RING) || (state_q == ST_SNOOZE))) begin
      sec_cnt_q <= sec_cnt_q + SEC_W'(1);
    end
  end

  // Buzzer starts high on every RING entry and toggles at 2 Hz for a 1 Hz tone.
  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      buzzer_q <= 1'b0;
    end else if (state_d != ST_RING) begin
      buzzer_q <= 1'b0;
    end else if (state_q != ST_RING) begin
      buzzer_q <= 1'b1;
    end else if (tick_2hz) begin
      buzzer_q <= ~buzzer_q;
    end
  end

  assign buzzer     = buzzer_q;
  assign ringing    = (state_q == ST_RING);
  assign snoozing   = (state_q == ST_SNOOZE);
  assign snooze_cnt = snz_cnt_q;
  assign sec_cnt    = sec_cnt_q;

endmodule

// File: tb/tb_alarm_responder.sv
// Bench for alarm_responder: directed alarm scenarios followed by random
// stimulus, every cycle compared against a behavioural alarm model.
module tb_alarm_responder;

  localparam int RT   = 4;
  localparam int SN   = 3;
  localparam int MAXS = 2;

  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 2;
  localparam int M_DONE = 3;

  logic       clk = 1'b0;
  logic       cr = 1'b0;
  logic       en = 1'b0;
  logic       match = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       tick_2hz = 1'b0;
  logic       stop_btn = 1'b0;
  logic       snooze_btn = 1'b0;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_cnt;
  logic [8:0] sec_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model of the alarm event
  int m_mode;
  int m_sec;
  int m_scnt;
  int m_half;
  bit m_armed;
  bit m_pm, m_ps, m_pz;

  bit r_m, r_e, r_s, r_z;

  alarm_responder #(
    .RING_TIMEOUT_S (RT),
    .SNOOZE_S       (SN),
    .MAX_SNOOZE     (MAXS)
  ) dut (
    .clk        (clk),
    .cr         (cr),
    .en         (en),
    .match      (match),
    .tick_1hz   (tick_1hz),
    .tick_2hz   (tick_2hz),
    .stop_btn   (stop_btn),
    .snooze_btn (snooze_btn),
    .buzzer     (buzzer),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt),
    .sec_cnt    (sec_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_sec   = 0;
    m_scnt  = 0;
    m_half  = 0;
    m_armed = 1'b0;
    m_pm    = 1'b0;
    m_ps    = 1'b0;
    m_pz    = 1'b0;
  endtask

  task automatic enter(input int mode);
    m_mode = mode;
    m_sec  = 0;
    m_half = 0;
    if (mode == M_IDLE) m_scnt = 0;
  endtask

  task automatic model_step();
    bit rm, rs, rz;
    rm = m_armed && match && !m_pm;
    rs = m_armed && stop_btn && !m_ps;
    rz = m_armed && snooze_btn && !m_pz;
    m_pm = match;
    m_ps = stop_btn;
    m_pz = snooze_btn;
    m_armed = 1'b1;
    if (!en) begin
      enter(M_IDLE);
    end else begin
      case (m_mode)
        M_IDLE: if (rm) enter(M_RING);
        M_RING: begin
          if (rs) enter(M_DONE);
          else if (rz) begin
            if (m_scnt < MAXS) begin
              m_scnt++;
              enter(M_SNZ);
            end else begin
              enter(M_DONE);
            end
          end else if (tick_1hz && (m_sec + 1 == RT)) enter(M_DONE);
          else begin
            if (tick_1hz) m_sec++;
            if (tick_2hz) m_half++;
          end
        end
        M_SNZ: begin
          if (rs) enter(M_DONE);
          else if (tick_1hz && (m_sec + 1 == SN)) enter(M_RING);
          else if (tick_1hz) m_sec++;
        end
        default: if (!match) enter(M_IDLE);
      endcase
    end
  endtask

  task automatic compare_all();
    chk("ringing", 16'(ringing), 16'(m_mode == M_RING));
    chk("snoozing", 16'(snoozing), 16'(m_mode == M_SNZ));
    chk("buzzer", 16'(buzzer), 16'((m_mode == M_RING) && (m_half % 2 == 0)));
    chk("snooze_cnt", 16'(snooze_cnt), 16'(m_scnt));
    chk("sec_cnt", 16'(sec_cnt), 16'(m_sec));
  endtask

  // Called at a falling edge: drive, let the DUT clock once, compare at next fall.
  task automatic step(input bit m, input bit e, input bit s, input bit z,
                      input bit a, input bit b);
    match      = m;
    en         = e;
    stop_btn   = s;
    snooze_btn = z;
    tick_1hz   = a;
    tick_2hz   = b;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic async_reset();
    #2 cr = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_ringing", 16'(ringing), 16'd0);
    chk("rst_buzzer", 16'(buzzer), 16'd0);
    #1 cr = 1'b1;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    chk("reset_sec", 16'(sec_cnt), 16'd0);
    cr = 1'b1;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();

    // Ring, buzzer toggling, timeout after four seconds, back to idle
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("s1_ring", 16'(ringing), 16'd1);
    chk("s1_buz_first", 16'(buzzer), 16'd1);
    step(1, 1, 0, 0, 0, 1);
    chk("s1_buz_toggle", 16'(buzzer), 16'd0);
    step(1, 1, 0, 0, 1, 1);
    step(1, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0);
    chk("s1_sec3", 16'(sec_cnt), 16'd3);
    step(1, 1, 0, 0, 1, 0);
    chk("s1_timeout_ring", 16'(ringing), 16'd0);
    chk("s1_timeout_buz", 16'(buzzer), 16'd0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);

    // Snooze twice, third snooze ends the event
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    chk("s2_snoozing", 16'(snoozing), 16'd1);
    chk("s2_cnt1", 16'(snooze_cnt), 16'd1);
    repeat (3) step(1, 1, 0, 0, 1, 0);
    chk("s2_rering", 16'(ringing), 16'd1);
    step(1, 1, 0, 1, 0, 0);
    chk("s2_cnt2", 16'(snooze_cnt), 16'd2);
    repeat (3) step(1, 1, 0, 0, 1, 0);
    step(1, 1, 0, 1, 0, 0);
    chk("s2_done_ring", 16'(ringing), 16'd0);
    chk("s2_done_snz", 16'(snoozing), 16'd0);
    repeat (5) step(1, 1, 0, 0, 1, 1);
    chk("s2_no_rering", 16'(ringing), 16'd0);
    step(0, 1, 0, 0, 0, 0);

    // Stop and snooze together; stop coincident with the timeout tick
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    chk("s3_both_ring", 16'(ringing), 16'd0);
    chk("s3_both_cnt", 16'(snooze_cnt), 16'd0);
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0, 1, 0);
    step(1, 1, 1, 0, 1, 0);
    chk("s3_stop_tick", 16'(ringing), 16'd0);
    step(0, 1, 0, 0, 0, 0);

    // Disable while ringing; re-enable during held match stays idle
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("s4_dis_ring", 16'(ringing), 16'd0);
    chk("s4_dis_buz", 16'(buzzer), 16'd0);
    repeat (3) step(1, 1, 0, 0, 1, 1);
    chk("s4_reen_idle", 16'(ringing), 16'd0);
    step(0, 1, 0, 0, 0, 0);

    // Asynchronous clear mid-snooze with match held
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0);
    chk("s5_snz_sec", 16'(sec_cnt), 16'd2);
    async_reset();
    repeat (4) step(1, 1, 0, 0, 1, 1);
    chk("s5_no_ring", 16'(ringing), 16'd0);
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("s5_new_ring", 16'(ringing), 16'd1);

    // Match held after stop, then a fresh match starts a new event
    step(1, 1, 0, 1, 0, 0);
    chk("s6_cnt1", 16'(snooze_cnt), 16'd1);
    repeat (3) step(1, 1, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("s6_done_cnt", 16'(snooze_cnt), 16'd1);
    repeat (10) step(1, 1, 0, 0, 1, 1);
    chk("s6_held_ring", 16'(ringing), 16'd0);
    step(0, 1, 0, 0, 0, 0);
    chk("s6_idle_cnt", 16'(snooze_cnt), 16'd0);
    step(1, 1, 0, 0, 0, 0);
    chk("s6_ring_again", 16'(ringing), 16'd1);
    chk("s6_ring_cnt", 16'(snooze_cnt), 16'd0);

    r_m = match;
    r_e = en;
    r_s = stop_btn;
    r_z = snooze_btn;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end else begin
        if ($urandom_range(0, 24) == 0) r_m = ~r_m;
        if ($urandom_range(0, 11) == 0) r_s = ~r_s;
        if ($urandom_range(0, 9) == 0) r_z = ~r_z;
        if (r_e) begin
          if ($urandom_range(0, 149) == 0) r_e = 1'b0;
        end else if ($urandom_range(0, 4) == 0) begin
          r_e = 1'b1;
        end
        step(r_m, r_e, r_s, r_z, ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
